snoop_memory_ctrl: RTL

SNOOP_MEMORY_CTRL -- requirements
Module: snoop_memory_ctrl

---
 rtl/snoop_memory_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/snoop_memory_ctrl.sv
// rtl/snoop_memory_ctrl.sv - L2-side memory controller serving L1 snooper misses and evictions
//
// Parameters:
//   READ_LATENCY  - cycles from read accept to response strobe (2..15)
//   WRITE_LATENCY - cycles from eviction accept to array commit (1..15)
//   LINE_BITS     - index width of the 128-bit line store (index = addr[LINE_BITS+3:4])
// Ports:
//   clk, reset          - clock; asynchronous active-high reset
//   req_addr            - line address from the snooper bus (bits [3:0] ignored)
//   req_read_valid      - miss read request
//   req_evict_wren      - eviction write request, always accepted
//   req_evict_line      - evicted cacheline
//   neighbor_hit        - sister cache serves the read; cancels an accept or in-flight read
//   resp_hold           - defer the response strobe while asserted
//   resp_line           - returned cacheline, zero whenever resp_valid is low
//   resp_valid          - one-cycle response strobe
//   read_ready          - read FSM idle, a read request can be accepted
//   err_overrun         - sticky: a read arrived while busy and was dropped
//   read_count          - accepted reads, saturating
//   evict_count         - accepted evictions, saturating
module snoop_memory_ctrl #(
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2,
  parameter int LINE_BITS     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  req_addr,
  input  logic         req_read_valid,
  input  logic         req_evict_wren,
  input  logic [127:0] req_evict_line,
  input  logic         neighbor_hit,
  input  logic         resp_hold,
  output logic [127:0] resp_line,
  output logic         resp_valid,
  output logic         read_ready,
  output logic         err_overrun,
  output logic [15:0]  read_count,
  output logic [15:0]  evict_count
);

  localparam int LINES = 1 << LINE_BITS;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic {W_EMPTY, W_PEND} w_state_t;

  // Backing store: intentionally not reset, contents survive a controller reset.
  logic [127:0] mem [LINES];

  r_state_t             r_state, r_next;
  logic [3:0]           r_cnt;
  logic [LINE_BITS-1:0] r_index;
  logic                 rd_accept;

  w_state_t             w_state;
  logic [3:0]           w_cnt;
  logic [LINE_BITS-1:0] w_index;
  logic [127:0]         w_line;
  logic                 commit;

  logic [LINE_BITS-1:0] req_index;
  logic                 unused_addr_bits;

  // Tag bits are never stored; only the index selects a line.
  assign req_index        = req_addr[LINE_BITS+3:4];
  assign unused_addr_bits = ^{req_addr[31:LINE_BITS+4], req_addr[3:0]};

  // Read FSM: next state and outputs
  always_comb begin
    r_next     = r_state;
    rd_accept  = 1'b0;
    read_ready = (r_state == R_IDLE);
    resp_valid = (r_state == R_RESP) & ~resp_hold;
    resp_line  = '0;
    case (r_state)
      R_IDLE: begin
        if (req_read_valid && !neighbor_hit) begin
          r_next    = R_WAIT;
          rd_accept = 1'b1;
        end
      end
      R_WAIT: begin
        if (neighbor_hit)    r_next = R_IDLE;
        else if (r_cnt == 0) r_next = R_RESP;
      end
      R_RESP: begin
        if (!resp_hold) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
    // A pending eviction to the same index is newer than the array copy.
    if (resp_valid) begin
      if (w_state == W_PEND && w_index == r_index) resp_line = w_line;
      else                                         resp_line = mem[r_index];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= R_IDLE;
      r_cnt       <= '0;
      r_index     <= '0;
      err_overrun <= 1'b0;
      read_count  <= '0;
    end else begin
      r_state <= r_next;
      if (rd_accept) begin
        r_cnt   <= 4'(READ_LATENCY - 2);
        r_index <= req_index;
        if (read_count != 16'hFFFF) read_count <= read_count + 16'd1;
      end else if (r_state == R_WAIT && r_cnt != 0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (req_read_valid && r_state != R_IDLE) err_overrun <= 1'b1;
    end
  end

  // A pending entry leaves the buffer either when its timer expires or when a
  // newer eviction displaces it; either way it lands in the array first.
  assign commit = (w_state == W_PEND) && (req_evict_wren || w_cnt == 0) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state     <= W_EMPTY;
      w_cnt       <= '0;
      w_index     <= '0;
      w_line      <= '0;
      evict_count <= '0;
    end else begin
      if (req_evict_wren) begin
        w_state <= W_PEND;
        w_cnt   <= 4'(WRITE_LATENCY - 1);
        w_index <= req_index;
        w_line  <= req_evict_line;
        if (evict_count != 16'hFFFF) evict_count <= evict_count + 16'd1;
      end else if (w_state == W_PEND) begin
        if (w_cnt == 0) w_state <= W_EMPTY;
        else            w_cnt   <= w_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) mem[w_index] <= w_line;
  end

endmodule
